// File: rtl/systolic_array_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_array_ctrl
//   Sequencer for a 2x2 weight-stationary systolic array. Takes one job
//   (four weights + number of input vectors), loads the weights into the
//   array, streams (x0,x1) vectors with x1 skewed one cycle behind x0, then
//   re-aligns the array's y0/y1 outputs into result pairs held in a small
//   FIFO for a valid/ready consumer.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cmd_*                 job request (valid/ready), weights, vector count
//   in_*                  input vector stream (valid/ready)
//   out_*                 result pair stream (valid/ready), head of FIFO
//   arr_*                 connections to the systolic array
//   done                  one-cycle pulse when a job has fully completed
//
// Handshake rule for every valid/ready pair: a transfer happens on the
// rising edge where valid && ready are both high; valid does not depend on
// ready.
// ---------------------------------------------------------------------------
module systolic_array_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOAD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_WIDTH-1:0]  cmd_w00,
  input  logic [DATA_WIDTH-1:0]  cmd_w01,
  input  logic [DATA_WIDTH-1:0]  cmd_w10,
  input  logic [DATA_WIDTH-1:0]  cmd_w11,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_x0,
  input  logic [DATA_WIDTH-1:0]  in_x1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_y0,
  output logic [DATA_WIDTH-1:0]  out_y1,
  output logic                   arr_load_weights,
  output logic                   arr_start,
  output logic [DATA_WIDTH-1:0]  arr_w00,
  output logic [DATA_WIDTH-1:0]  arr_w01,
  output logic [DATA_WIDTH-1:0]  arr_w10,
  output logic [DATA_WIDTH-1:0]  arr_w11,
  output logic [DATA_WIDTH-1:0]  arr_x0,
  output logic [DATA_WIDTH-1:0]  arr_x1,
  input  logic [DATA_WIDTH-1:0]  arr_y0,
  input  logic [DATA_WIDTH-1:0]  arr_y1,
  output logic                   done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state, next_state;

  logic [LW-1:0]           load_cnt;
  logic                    load_last;
  logic [COUNT_WIDTH-1:0]  count, issued;
  logic [DATA_WIDTH-1:0]   w00_q, w01_q, w10_q, w11_q;
  logic [2:0]              tags;       // tags[k] set => vector issued k+1 cycles ago
  logic [1:0]              inflight;
  logic [DATA_WIDTH-1:0]   x1_skew;
  logic [DATA_WIDTH-1:0]   y0_d;
  logic                    accept;

  logic [2*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             fifo_count;
  logic [PW+1:0]           occupancy;
  logic                    fifo_empty, push, pop;

  assign load_last  = (load_cnt == LW'(LOAD_CYCLES - 1));
  assign inflight   = 2'(tags[0]) + 2'(tags[1]) + 2'(tags[2]);
  assign occupancy  = (PW+2)'(fifo_count) + (PW+2)'(inflight);
  assign fifo_empty = (fifo_count == '0);
  assign accept     = in_valid && in_ready;
  // y1 of a vector arrives one cycle after its y0, so the pair completes
  // when its tag reaches the last stage.
  assign push       = tags[2];
  assign pop        = out_valid && out_ready;

  // Next-state and FSM outputs
  always_comb begin
    next_state       = state;
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    arr_load_weights = 1'b0;
    arr_start        = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = LOAD;
      end
      LOAD: begin
        arr_load_weights = 1'b1;
        if (load_last) next_state = (count == '0) ? DRAIN : RUN;
      end
      RUN: begin
        arr_start = 1'b1;
        // Never issue more than the FIFO can absorb, counting results still
        // inside the array, so a push can never meet a full FIFO.
        in_ready  = (issued < count) && (occupancy < (PW+2)'(FIFO_DEPTH));
        if (issued == count) next_state = DRAIN;
      end
      DRAIN: begin
        arr_start = 1'b1;
        if ((inflight == 2'd0) && fifo_empty) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state, job registers, issue tracking, FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_cnt   <= '0;
      count      <= '0;
      issued     <= '0;
      w00_q      <= '0;
      w01_q      <= '0;
      w10_q      <= '0;
      w11_q      <= '0;
      tags       <= '0;
      x1_skew    <= '0;
      y0_d       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cmd_valid) begin
        w00_q    <= cmd_w00;
        w01_q    <= cmd_w01;
        w10_q    <= cmd_w10;
        w11_q    <= cmd_w11;
        count    <= cmd_count;
        issued   <= '0;
        load_cnt <= '0;
      end
      if (state == LOAD) load_cnt <= load_cnt + LW'(1);
      if (accept) issued <= issued + COUNT_WIDTH'(1);
      tags    <= {tags[1:0], accept};
      x1_skew <= accept ? in_x1 : '0;
      y0_d    <= arr_y0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: it is only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {y0_d, arr_y1};
  end

  assign out_valid = !fifo_empty;
  assign out_y0    = out_valid ? fifo_mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign out_y1    = out_valid ? fifo_mem[rd_ptr][DATA_WIDTH-1:0] : '0;

  assign arr_w00 = w00_q;
  assign arr_w01 = w01_q;
  assign arr_w10 = w10_q;
  assign arr_w11 = w11_q;
  assign arr_x0  = accept ? in_x0 : '0;
  assign arr_x1  = x1_skew;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_ctrl
//   Directed bench for systolic_array_ctrl. Contains a behavioural model of
//   the 2x2 array (y0 two cycles after issue, y1 three cycles after), driver
//   tasks for the job and input streams, and a result scoreboard: expected
//   pairs are queued when a vector is accepted and a monitor pops and
//   compares them whenever a result is consumed.
// ---------------------------------------------------------------------------
module tb_systolic_array_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_w00, cmd_w01, cmd_w10, cmd_w11, cmd_count;
  logic       in_valid, in_ready;
  logic [7:0] in_x0, in_x1;
  logic       out_valid, out_ready;
  logic [7:0] out_y0, out_y1;
  logic       arr_load_weights, arr_start;
  logic [7:0] arr_w00, arr_w01, arr_w10, arr_w11, arr_x0, arr_x1;
  logic [7:0] arr_y0, arr_y1;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  // Vector table: inputs and hand-computed results
  logic [7:0] vx0[16], vx1[16], ve0[16], ve1[16];

  systolic_array_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w00(cmd_w00), .cmd_w01(cmd_w01), .cmd_w10(cmd_w10), .cmd_w11(cmd_w11),
    .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
    .out_valid(out_valid), .out_ready(out_ready), .out_y0(out_y0), .out_y1(out_y1),
    .arr_load_weights(arr_load_weights), .arr_start(arr_start),
    .arr_w00(arr_w00), .arr_w01(arr_w01), .arr_w10(arr_w10), .arr_w11(arr_w11),
    .arr_x0(arr_x0), .arr_x1(arr_x1), .arr_y0(arr_y0), .arr_y1(arr_y1),
    .done(done)
  );

  // Clock
  always #5 clk = ~clk;

  // Array model: weights captured on load, x histories for the skewed timing
  logic [7:0] m_w00, m_w01, m_w10, m_w11;
  logic [7:0] x0_d1, x0_d2, x0_d3, x1_d1, x1_d2;
  always @(posedge clk) begin
    if (arr_load_weights) begin
      m_w00 <= arr_w00;
      m_w01 <= arr_w01;
      m_w10 <= arr_w10;
      m_w11 <= arr_w11;
    end
    x0_d1 <= arr_x0;
    x0_d2 <= x0_d1;
    x0_d3 <= x0_d2;
    x1_d1 <= arr_x1;
    x1_d2 <= x1_d1;
  end
  assign arr_y0 = m_w00 * x0_d2 + m_w10 * x1_d1;
  assign arr_y1 = m_w01 * x0_d3 + m_w11 * x1_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got y0=%0d y1=%0d expected none", out_y0, out_y1);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("result_y0", 32'(out_y0), 32'(e[15:8]));
        check("result_y1", 32'(out_y1), 32'(e[7:0]));
      end
    end
  end

  task automatic set_vec(input int i, input logic [7:0] x0, x1, e0, e1);
    vx0[i] = x0; vx1[i] = x1; ve0[i] = e0; ve1[i] = e1;
  endtask

  // Driver: issue one job; returns at posedge+1 after the command transfer
  task automatic start_job(input logic [7:0] w00, w01, w10, w11, cnt);
    int n;
    cmd_valid = 1'b1;
    cmd_w00 = w00; cmd_w01 = w01; cmd_w10 = w10; cmd_w11 = w11; cmd_count = cnt;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Driver: stream table entries first..first+num-1 within a cycle budget
  task automatic drive_vectors(input int first, input int num, input int budget,
                               output int accepted, output int cycles);
    accepted = 0;
    cycles   = 0;
    while (cycles < budget && accepted < num) begin
      in_valid = 1'b1;
      in_x0 = vx0[first + accepted];
      in_x1 = vx1[first + accepted];
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ve0[first + accepted], ve1[first + accepted]});
        accepted++;
      end
      cycles++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait for the done pulse (bounded), then check the return to IDLE
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_results_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc;
    set_vec(0, 1, 1, 4, 6);
    set_vec(1, 1, 1, 4, 6);
    set_vec(2, 2, 3, 11, 16);
    set_vec(3, 0, 5, 15, 20);
    set_vec(4, 0, 1, 3, 4);
    set_vec(5, 1, 2, 7, 10);
    set_vec(6, 2, 3, 11, 16);
    set_vec(7, 3, 4, 15, 22);
    set_vec(8, 4, 5, 19, 28);
    set_vec(9, 5, 6, 23, 34);
    set_vec(10, 6, 7, 27, 40);
    set_vec(11, 7, 8, 31, 46);
    set_vec(12, 16, 0, 0, 0);
    set_vec(13, 1, 1, 32, 32);
    set_vec(14, 1, 1, 4, 6);
    set_vec(15, 2, 3, 11, 16);

    // Reset
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cmd_w00 = '0; cmd_w01 = '0; cmd_w10 = '0; cmd_w11 = '0; cmd_count = '0;
    in_x0 = '0; in_x1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_arr_start", 32'(arr_start), 32'd0);
    check("rst_arr_load", 32'(arr_load_weights), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_arr_w11", 32'(arr_w11), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single vector
    out_ready = 1'b1;
    start_job(1, 2, 3, 4, 1);
    @(negedge clk);
    check("t1_load_pulse", 32'(arr_load_weights), 32'd1);
    check("t1_arr_w10", 32'(arr_w10), 32'd3);
    check("t1_in_ready_load", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    drive_vectors(0, 1, 20, acc, cyc);
    check("t1_accepted", 32'(acc), 32'd1);
    check("t1_cycles", 32'(cyc), 32'd1);
    wait_done("t1");

    // 2: three vectors back to back
    start_job(1, 2, 3, 4, 3);
    drive_vectors(1, 3, 20, acc, cyc);
    check("t2_accepted", 32'(acc), 32'd3);
    check("t2_no_stall", 32'(cyc), 32'd4);
    wait_done("t2");

    // 3: consumer stalled, issue must stop at FIFO capacity
    out_ready = 1'b0;
    start_job(1, 2, 3, 4, 8);
    drive_vectors(4, 8, 12, acc, cyc);
    check("t3_stall_accepts", 32'(acc), 32'd4);
    check("t3_out_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drive_vectors(8, 4, 60, acc, cyc);
    check("t3_rest_accepted", 32'(acc), 32'd4);
    wait_done("t3");

    // 4: arithmetic wrap
    start_job(16, 16, 16, 16, 2);
    drive_vectors(12, 2, 20, acc, cyc);
    check("t4_accepted", 32'(acc), 32'd2);
    wait_done("t4");

    // 5: empty job
    start_job(5, 6, 7, 8, 0);
    @(negedge clk);
    check("t5_load_pulse", 32'(arr_load_weights), 32'd1);
    check("t5_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_load_off", 32'(arr_load_weights), 32'd0);
    check("t5_no_result", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_done_one_cycle", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    // 6: reset mid-run with buffered results
    out_ready = 1'b0;
    start_job(1, 2, 3, 4, 4);
    drive_vectors(14, 2, 10, acc, cyc);
    check("t6_accepted", 32'(acc), 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_buffered_valid", 32'(out_valid), 32'd1);
    check("t6_head_y0", 32'(out_y0), 32'd4);
    check("t6_head_y1", 32'(out_y1), 32'd6);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_arr_start", 32'(arr_start), 32'd0);
    check("t6_arr_x1", 32'(arr_x1), 32'd0);
    check("t6_arr_w00", 32'(arr_w00), 32'd0);
    check("t6_out_y0", 32'(out_y0), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    start_job(1, 2, 3, 4, 1);
    drive_vectors(2, 1, 20, acc, cyc);
    check("t6_new_accepted", 32'(acc), 32'd1);
    wait_done("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
